// File: rtl/lif_pkg.sv
// Shared helpers and constants for the leaky integrate-and-fire neuron array.
package lif_pkg;

   localparam int RESET_SUB  = 0;
   localparam int RESET_ZERO = 1;

   // Operands are at most w bits wide, so the sum fits one extra bit before clamping to 2^w-1.
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                           input int w);
      logic [32:0] sum;
      logic [32:0] max_v;
      sum   = {1'b0, a} + {1'b0, b};
      max_v = (33'd1 << w) - 33'd1;
      return (sum > max_v) ? max_v[31:0] : sum[31:0];
   endfunction

   function automatic logic [31:0] popcount(input logic [63:0] v);
      logic [31:0] c;
      c = '0;
      for (int i = 0; i < 64; i++) begin
         c = c + 32'(v[i]);
      end
      return c;
   endfunction

endpackage

// File: rtl/lif_neuron.sv
// One leaky integrate-and-fire neuron: saturating membrane register, refractory timer, spike pulse.
module lif_neuron
   import lif_pkg::*;
#(
   parameter int W          = 8,
   parameter int THRESHOLD  = 239,
   parameter int LEAK_SHIFT = 1,
   parameter int REFRACT    = 15,
   parameter int RESET_MODE = RESET_SUB
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [W-1:0] cur_i,
   output logic [W-1:0] mem_o,
   output logic         spike_o,
   output logic         fire_o
);

   localparam int TW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

   logic [W-1:0]  u;
   logic [W-1:0]  u_next;
   logic [TW-1:0] timer;
   logic [TW-1:0] timer_next;
   logic          fire;
   logic          spike_q;

   always_comb begin
      fire       = (timer == '0) && (u >= W'(THRESHOLD));
      u_next     = u;
      timer_next = timer;
      if (fire) begin
         // u >= THRESHOLD here, so the subtraction cannot underflow.
         if (RESET_MODE == RESET_ZERO) begin
            u_next = cur_i;
         end else begin
            u_next = W'(sat_add(32'(u - W'(THRESHOLD)), 32'(cur_i), W));
         end
         timer_next = TW'(REFRACT);
      end else begin
         u_next = W'(sat_add(32'(u >> LEAK_SHIFT), 32'(cur_i), W));
         if (timer != '0) begin
            timer_next = timer - TW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         u       <= '0;
         timer   <= '0;
         spike_q <= 1'b0;
      end else if (en) begin
         u       <= u_next;
         timer   <= timer_next;
         spike_q <= fire;
      end else begin
         spike_q <= 1'b0;
      end
   end

   assign mem_o   = u;
   assign spike_o = spike_q;
   assign fire_o  = fire;

endmodule

// File: rtl/lif_array.sv
// Array of N independent LIF neurons with a registered per-edge spike population count.
module lif_array
   import lif_pkg::*;
#(
   parameter int N          = 4,
   parameter int W          = 8,
   parameter int THRESHOLD  = 239,
   parameter int LEAK_SHIFT = 1,
   parameter int REFRACT    = 15,
   parameter int RESET_MODE = RESET_SUB,
   localparam int CW        = $clog2(N + 1)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           en,
   input  logic [N*W-1:0] cur_i,
   output logic [N-1:0]   spike_o,
   output logic [N*W-1:0] mem_o,
   output logic [CW-1:0]  spike_cnt_o
);

   logic [N-1:0] fire;

   for (genvar g = 0; g < N; g++) begin : g_neuron
      lif_neuron #(
         .W          (W),
         .THRESHOLD  (THRESHOLD),
         .LEAK_SHIFT (LEAK_SHIFT),
         .REFRACT    (REFRACT),
         .RESET_MODE (RESET_MODE)
      ) u_neuron (
         .clk     (clk),
         .rst_n   (rst_n),
         .en      (en),
         .cur_i   (cur_i[g*W +: W]),
         .mem_o   (mem_o[g*W +: W]),
         .spike_o (spike_o[g]),
         .fire_o  (fire[g])
      );
   end

   // Count is taken from the same fire vector that loads spike_o, so both align on one edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spike_cnt_o <= '0;
      end else if (en) begin
         spike_cnt_o <= CW'(popcount(64'(fire)));
      end else begin
         spike_cnt_o <= '0;
      end
   end

endmodule

// File: doc/lif_array.md
Name: lif_array

Overview:
- Parametrised array of N independent leaky integrate-and-fire neurons sharing one clock, enable and reset.
- Each neuron has:
  - a W-bit saturating membrane potential,
  - a configurable leak shift,
  - a configurable refractory period,
  - a selectable post-spike reset mode.
- Registered per-neuron spike pulses and a registered spike population count feed downstream spike routers and rate monitors.

Parameters:
- N, 4, neuron count (>=1)
- W, 8, membrane potential and input current width (>=2)
- THRESHOLD, 239, firing threshold; legal range 1..2^W-1
- LEAK_SHIFT, 1, right-shift applied to U each non-firing update; legal range 0..W-1
- REFRACT, 15, refractory cycles after a spike (0 = none)
- RESET_MODE, 0, post-spike reset: 0 = subtract threshold, 1 = reset to zero
- Local TW = max(1, clog2(REFRACT+1)), refractory timer width
- Local CW = clog2(N+1), spike count width

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  update enable; 0 freezes U and timers.
- cur_i  in  N*W  input currents, unsigned; neuron i uses bits [i*W +: W].
- spike_o  out  N  registered one-cycle spike pulse per neuron.
- mem_o  out  N*W  current membrane potential per neuron (register view).
- spike_cnt_o  out  CW  registered count of neurons that fired on the last enabled edge.

Behaviour:
- Reset: rst_n=0 asynchronously clears all U, all timers, spike_o and spike_cnt_o to 0. Reset mid-run discards refractory state.
- Per neuron i, on a rising edge with en=1:
  - fire = (timer==0) && (U >= THRESHOLD). U is the registered value before the edge.
  - If fire and RESET_MODE=0: U <= sat(U - THRESHOLD + I). The subtraction is never negative because U >= THRESHOLD.
  - If fire and RESET_MODE=1: U <= I.
  - If fire: timer <= REFRACT.
  - If not fire: U <= sat((U >> LEAK_SHIFT) + I). If timer != 0, timer <= timer - 1.
  - The neuron integrates during refractory but cannot fire until timer == 0.
  - spike_o[i] <= fire.
- sat(x): compute in W+1 bits, clamp to 2^W-1. Never wraps.
- spike_cnt_o <= popcount(fire[N-1:0]) on the same edge as spike_o.
- en=0 edge: U and timers hold; spike_o <= 0; spike_cnt_o <= 0. Spike pulses never repeat while disabled.
- Latency: a neuron whose U >= THRESHOLD before edge k asserts spike_o after edge k, for exactly one cycle, provided en stays 1.
- Neurons are fully independent; any number may fire on the same edge.
- THRESHOLD=2^W-1: firing requires saturation. REFRACT=0: a neuron may fire on consecutive edges.

Decomposition:
- Package lif_pkg holds:
  - sat_add function (W-generic via W+1-bit intermediate),
  - popcount function,
  - the RESET_SUB / RESET_ZERO mode constants.
- Sub-module lif_neuron: one neuron (U, timer, spike register) with the same parameters. Instantiated N times via generate.
- The top level owns slicing of cur_i and mem_o and the popcount register.

Test Plan (defaults unless stated; neuron 0 driven, others I=0):
- Reset: run with I=120, assert rst_n=0 between edges -> spike_o, spike_cnt_o and all mem_o read 0 immediately, before the next edge.
- Leak/integrate: I=120, en=1 from reset -> mem_o[0] reads 120,180,210,225,232,236,238,239 after edges 1-8. Edge 9 fires: U=120, spike_o[0]=1 for one cycle, spike_cnt_o=1.
- Refractory: continue the previous scenario -> U sits at 239 from edge 16 but no spike until edge 25. Spike period is 16 edges; spike_o[0] is low on edges 10-24.
- Saturation: I=255 -> U=255 after edge 1. Edge 2 fires with U = sat(255-239+255) = 255, never wrapping to 15.
- RESET_MODE=1, REFRACT=0: I=240 -> edge 1 U=240; edge 2 fires, U=240. Neuron fires on every edge from 2 onward.
- Parallel/enable: all four neurons I=255 -> all fire on edge 2, spike_cnt_o=4. Then drop en for 3 edges -> spike_o=0, spike_cnt_o=0, mem_o unchanged. Raise en -> updates resume from the held state.
